config_stream_loader: RTL

Serial configuration front end for the tile array. It accepts a bit-serial bitstream over a valid/ready handshake, deserializes it into 32-bit address/data word pairs and drives them onto the shared `config_addr`/`config_data` bus that every tile's address matchers decode. Between word pairs it parks the bus on a reserved idle address so that no tile's configuration register is enabled.

---
 rtl/config_stream_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/config_stream_loader.sv
// Bit-serial configuration loader: deserializes header + address/data frames and
// presents each pair on the shared tile config bus for HOLD_CYCLES cycles.
`timescale 1ns/1ps
module config_stream_loader #(
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [15:0] MAGIC       = 16'hA5C3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_ADDR, S_DATA, S_ISSUE, S_DONE, S_ERROR
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [30:0] shift_q, shift_d;
  logic [15:0] nframes_q, nframes_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_data_q, bus_data_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] words_q, words_d;

  logic        take, last_bit;
  logic [31:0] word;

  assign bit_ready = (state_q == S_HEADER) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign busy      = bit_ready || (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);

  assign config_addr  = bus_addr_q;
  assign config_data  = bus_data_q;
  assign words_loaded = words_q;

  // word is the full 32-bit value including the bit being accepted this edge
  assign take     = bit_valid & bit_ready;
  assign word     = {shift_q, bit_in};
  assign last_bit = take && (cnt_q == 6'd31);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    nframes_d  = nframes_q;
    addr_d     = addr_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    hold_d     = hold_q;
    words_d    = words_q;

    if (take) begin
      shift_d = word[30:0];
      cnt_d   = cnt_q + 6'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        words_d = '0;
        cnt_d   = '0;
        if (start) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (last_bit) begin
          nframes_d = word[15:0];
          if (word[31:16] != MAGIC)   state_d = S_ERROR;
          else if (word[15:0] == '0)  state_d = S_DONE;
          else                        state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (last_bit) begin
          addr_d  = word;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_bit) begin
          bus_addr_d = addr_q;
          bus_data_d = word;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hold_q == HOLD_LAST) begin
          words_d    = words_q + 16'd1;
          bus_addr_d = IDLE_ADDR;
          bus_data_d = '0;
          state_d    = (words_d == nframes_q) ? S_DONE : S_ADDR;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          words_d = '0;
          state_d = S_HEADER;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // every state starts its own bit/hold count from zero
    if (state_d != state_q) begin
      cnt_d  = '0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      nframes_q  <= '0;
      addr_q     <= '0;
      bus_addr_q <= IDLE_ADDR;
      bus_data_q <= '0;
      hold_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      nframes_q  <= nframes_d;
      addr_q     <= addr_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      hold_q     <= hold_d;
      words_q    <= words_d;
    end
  end

endmodule
